salidzinatajs: RTL and testbench

Registered equality/magnitude comparator for the binary number game. It compares the player's 4-bit guess (num_1) against the target (num_2) and reports match plus greater/less. It also keeps a saturating count of hits and the current run of consecutive hits. It sits between the switch/input logic and the scoring/display logic.

---
 rtl/salidzinatajs_pkg.sv | 13 +
 rtl/salidzinatajs_core.sv | 18 +
 rtl/salidzinatajs.sv | 73 +++++++
 tb/tb_salidzinatajs.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/salidzinatajs_pkg.sv
// Shared constants and result encoding for the binary number game comparator.
package salidzinatajs_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_GT = 2'd1,
    CMP_LT = 2'd2
  } cmp_res_t;

endpackage

// File: rtl/salidzinatajs_core.sv
// Combinational unsigned comparator; exactly one of eq/gt/lt is high.
module salidzinatajs_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  always_comb begin
    eq = (a == b);
    gt = (a > b);
    lt = (a < b);
  end

endmodule

// File: rtl/salidzinatajs.sv
// Registered comparator with saturating hit counter and consecutive-hit streak.
module salidzinatajs
  import salidzinatajs_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmp_en,
  input  logic             clr,
  input  logic [WIDTH-1:0] num_1,
  input  logic [WIDTH-1:0] num_2,
  output logic             match,
  output logic             gt,
  output logic             lt,
  output logic             valid,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] streak
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic eq_c;
  logic gt_c;
  logic lt_c;

  salidzinatajs_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a  (num_1),
    .b  (num_2),
    .eq (eq_c),
    .gt (gt_c),
    .lt (lt_c)
  );

  // Flags only move on an accepted strobe; valid marks that strobe for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= cmp_en;
      if (cmp_en) begin
        match <= eq_c;
        gt    <= gt_c;
        lt    <= lt_c;
      end
    end
  end

  // clr has priority over any strobe in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
      streak    <= '0;
    end else if (clr) begin
      hit_count <= '0;
      streak    <= '0;
    end else if (cmp_en) begin
      if (eq_c) begin
        if (hit_count != CNT_MAX) hit_count <= hit_count + CNT_W'(1);
        if (streak != CNT_MAX)    streak    <= streak + CNT_W'(1);
      end else begin
        streak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_salidzinatajs.sv
// Self-checking bench for salidzinatajs: per-cycle model comparison plus literal spot checks.
module tb_salidzinatajs;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int          SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmp_en;
  logic             clr;
  logic [WIDTH-1:0] num_1;
  logic [WIDTH-1:0] num_2;
  logic             match;
  logic             gt;
  logic             lt;
  logic             valid;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] streak;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference state, kept as plain integers.
  int m_match, m_gt, m_lt, m_valid, m_hits, m_streak;

  salidzinatajs #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmp_en    (cmp_en),
    .clr       (clr),
    .num_1     (num_1),
    .num_2     (num_2),
    .match     (match),
    .gt        (gt),
    .lt        (lt),
    .valid     (valid),
    .hit_count (hit_count),
    .streak    (streak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_match = 0; m_gt = 0; m_lt = 0; m_valid = 0; m_hits = 0; m_streak = 0;
    end else begin
      int a, b;
      a = int'(num_1);
      b = int'(num_2);
      m_valid = cmp_en ? 1 : 0;
      if (cmp_en) begin
        m_match = (a == b) ? 1 : 0;
        m_gt    = (a > b) ? 1 : 0;
        m_lt    = (a < b) ? 1 : 0;
      end
      if (clr) begin
        m_hits   = 0;
        m_streak = 0;
      end else if (cmp_en) begin
        if (a == b) begin
          m_hits   = (m_hits + 1 > SAT) ? SAT : m_hits + 1;
          m_streak = (m_streak + 1 > SAT) ? SAT : m_streak + 1;
        end else begin
          m_streak = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("model_match", int'(match), m_match);
      chk("model_gt", int'(gt), m_gt);
      chk("model_lt", int'(lt), m_lt);
      chk("model_valid", int'(valid), m_valid);
      chk("model_hit_count", int'(hit_count), m_hits);
      chk("model_streak", int'(streak), m_streak);
    end
  end

  // Drive one cycle of inputs at negedge, return just after the following posedge.
  task automatic step(input int a, input int b, input bit en, input bit c);
    @(negedge clk);
    num_1  = WIDTH'(a);
    num_2  = WIDTH'(b);
    cmp_en = en;
    clr    = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    cmp_en = 1'b0;
    clr    = 1'b0;
    num_1  = '0;
    num_2  = '0;
    #12;
    rst_n = 1'b1;
    #1;
    chk("reset_match", int'(match), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_hit_count", int'(hit_count), 0);
    chk_en = 1'b1;

    step(0, 15, 1'b1, 1'b0);
    chk("z_vs_f_match", int'(match), 0);
    chk("z_vs_f_lt", int'(lt), 1);
    chk("z_vs_f_gt", int'(gt), 0);
    chk("z_vs_f_valid", int'(valid), 1);
    chk("z_vs_f_hits", int'(hit_count), 0);
    chk("z_vs_f_streak", int'(streak), 0);

    step(2, 7, 1'b1, 1'b0);
    chk("two_vs_seven_lt", int'(lt), 1);
    chk("two_vs_seven_match", int'(match), 0);
    step(0, 0, 1'b1, 1'b0);
    chk("zero_eq_match", int'(match), 1);
    chk("zero_eq_hits", int'(hit_count), 1);
    chk("zero_eq_streak", int'(streak), 1);

    step(0, 0, 1'b0, 1'b1);
    chk("clr_only_hits", int'(hit_count), 0);
    chk("clr_only_valid", int'(valid), 0);

    for (int i = 0; i < 5; i++) begin
      step(5, 5, 1'b1, 1'b0);
      chk("b2b_valid", int'(valid), 1);
    end
    chk("five_hits", int'(hit_count), 5);
    chk("five_streak", int'(streak), 5);

    step(9, 3, 1'b1, 1'b0);
    chk("nine_vs_three_gt", int'(gt), 1);
    chk("nine_vs_three_streak", int'(streak), 0);
    chk("nine_vs_three_hits", int'(hit_count), 5);

    step(3, 3, 1'b0, 1'b0);
    chk("idle_a_gt", int'(gt), 1);
    chk("idle_a_match", int'(match), 0);
    chk("idle_a_valid", int'(valid), 0);
    step(4, 1, 1'b0, 1'b0);
    chk("idle_b_gt", int'(gt), 1);
    chk("idle_b_hits", int'(hit_count), 5);
    chk("idle_b_streak", int'(streak), 0);

    // Asynchronous reset mid-cycle with a pending valid and nonzero counters.
    step(7, 7, 1'b1, 1'b0);
    chk("pre_reset_valid", int'(valid), 1);
    chk("pre_reset_hits", int'(hit_count), 6);
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    cmp_en = 1'b0;
    #1;
    chk("async_reset_match", int'(match), 0);
    chk("async_reset_valid", int'(valid), 0);
    chk("async_reset_hits", int'(hit_count), 0);
    chk("async_reset_streak", int'(streak), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < 260; i++) step(5, 5, 1'b1, 1'b0);
    chk("sat_hits", int'(hit_count), 255);
    chk("sat_streak", int'(streak), 255);
    step(1, 1, 1'b0, 1'b0);
    chk("sat_hold_hits", int'(hit_count), 255);
    chk("sat_hold_streak", int'(streak), 255);

    step(6, 6, 1'b1, 1'b1);
    chk("clr_strobe_match", int'(match), 1);
    chk("clr_strobe_valid", int'(valid), 1);
    chk("clr_strobe_hits", int'(hit_count), 0);
    chk("clr_strobe_streak", int'(streak), 0);

    step(0, 0, 1'b0, 1'b0);
    step(0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
